multi_driver: RTL and testbench
===============================

// Module: multi_driver
// PURPOSE
//  Sequencer wrapped around one multi-cycle unit that uses a start/in -> done/out interface.
//  Upstream side: valid/ready requests, buffered in a small FIFO.
//  Middle: issues one start pulse per request and waits for the unit's single-cycle done.
//  Downstream side: captures the unit's out into a held valid/ready response.
//  Guarantees the unit never sees start while an operation is outstanding.
// PARAMETERS
//  WIDTH   32  data width of requests, unit operands and responses
//  DEPTH   4   request FIFO entries; power of two, >= 2
//  TMO_W   8   width of watchdog counter (used only with MULTI_DRIVER_TIMEOUT_EN)
// PORTS
//  clock       in   1      single clock; all logic on posedge
//  reset       in   1      synchronous, active-high
//  req_valid   in   1      request offered
//  req_ready   out  1      request accepted when valid&ready
//  req_data    in   WIDTH  request operand
//  start       out  1      one-cycle issue pulse to unit
//  in          out  WIDTH  operand to unit; valid while start=1
//  done        in   1      unit completion pulse (one cycle)
//  out         in   WIDTH  unit result; sampled only when done=1
//  resp_valid  out  1      response held until accepted
//  resp_ready  in   1      downstream accepts response
//  resp_data   out  WIDTH  captured result
//  resp_err    out  1      response is a timeout (0 when feature compiled out)
// BEHAVIOUR
//  - Reset: FIFO empty; state IDLE; start=0, in=0, resp_valid=0, resp_data=0, resp_err=0, req_ready=1.
//  - FIFO: req_ready = !full. Push on req_valid&req_ready. Pop only on issue.
//    Push and pop in the same cycle are both legal, including when full (ready still follows !full).
//    No bypass: an empty FIFO takes >= 1 cycle from accept to issue.
//  - FSM states IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//    IDLE:  FIFO non-empty -> ISSUE.
//    ISSUE: start=1 for exactly one cycle, in=FIFO head, pop; -> WAIT.
//    WAIT:  done=1 -> latch out into resp_data, resp_err=0; -> RESP.
//    RESP:  resp_valid=1; resp_ready=1 -> clear resp_valid; -> IDLE.
//  - Outside ISSUE, start=0 and in=0.
//  - Throughput: one operation in flight. Minimum 4 cycles per request with zero unit latency.
//  - done outside WAIT is ignored: no state change, resp_data unchanged.
//  - done in the same cycle start is high is ignored; WAIT begins on the next cycle.
//  - Reset mid-operation: drop any in-flight operation, flush the FIFO, go to IDLE.
//    The unit is reset alongside, so a late done returns in IDLE and is ignored.
// CONFIGURATION
//  MULTI_DRIVER_TIMEOUT_EN defined:
//   - Watchdog clears on entering WAIT and increments each cycle spent in WAIT.
//   - Reaching 2**TMO_W-1 with no done -> RESP with resp_err=1, resp_data=0.
//   - A later stale done is ignored (not in WAIT).
//   - If done arrives in the same cycle as the terminal count, done wins.
//  Not defined: no counter; WAIT waits forever; resp_err tied 0.
// STRUCTURE
//  - Shared package multi_pkg: FSM state encoding (IDLE/ISSUE/WAIT/RESP, 2 bits),
//    default WIDTH, DEPTH and TMO_W constants.
//  - Sub-module multi_fifo: sync FIFO with push/pop/full/empty/head.
//    Pointers are log2(DEPTH)+1 bits; the MSB distinguishes full from empty.
//  - FSM, watchdog and response register live in the top module.
// TESTING
//  1. Reset, push req 0x0000_00A5; unit done 2 cycles after start with out=0x0000_00A5
//     -> single start pulse, in=0xA5, resp_valid with resp_data=0xA5.
//  2. Push 5 back-to-back requests (DEPTH=4), resp_ready=1 -> req_ready low while full;
//     5 responses in order; never 2 starts without a done between them.
//  3. Hold resp_ready=0 for 10 cycles -> resp_valid and resp_data stable; no new start;
//     FIFO accepts up to 4.
//  4. Inject done while IDLE and during RESP -> no state change, resp_data unchanged.
//  5. Assert reset during WAIT with 3 queued -> next cycle start=0, resp_valid=0, req_ready=1;
//     queued entries never issued.
//  6. MULTI_DRIVER_TIMEOUT_EN, TMO_W=4, unit never signals done -> resp_valid with
//     resp_err=1, resp_data=0, 15 cycles after entering WAIT; a later done is ignored.

Source files
------------

// File: rtl/multi_pkg.sv
// multi_driver shared definitions:
// FSM state encoding and default sizes.
package multi_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_TMO_W = 8;

endpackage

// File: rtl/multi_fifo.sv
// multi_fifo: synchronous request FIFO.
// Extra pointer MSB separates full from empty.
module multi_fifo
  import multi_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wp;
  logic [AW:0]      r_rp;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty = (r_wp == r_rp);
  assign o_full  = (r_wp[AW] != r_rp[AW]) &&
                   (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign o_head  = r_mem[r_rp[AW-1:0]];

  // a pop frees a slot, so push into a full FIFO is fine then
  assign w_do_push = i_push && (!o_full || i_pop);
  assign w_do_pop  = i_pop && !o_empty;

  // pointer update
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_do_push) r_wp <= r_wp + 1'b1;
      if (w_do_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  // storage write, no reset needed
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wp[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/multi_driver.sv
// multi_driver: FIFO-fed sequencer around a start/done unit.
// Optional watchdog: MULTI_DRIVER_TIMEOUT_EN.
module multi_driver
  import multi_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int TMO_W = DEF_TMO_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  output logic             start,
  output logic [WIDTH-1:0] in,
  input  logic             done,
  input  logic [WIDTH-1:0] out,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_err
);

  state_t           r_state;
  logic             r_start;
  logic [WIDTH-1:0] r_in;
  logic             r_resp_valid;
  logic [WIDTH-1:0] r_resp_data;
  logic             w_full;
  logic             w_empty;
  logic [WIDTH-1:0] w_head;
  logic             w_push;
  logic             w_pop;

  assign req_ready  = !w_full;
  assign w_push     = req_valid && req_ready;
  assign w_pop      = (r_state == S_ISSUE);
  assign start      = r_start;
  assign in         = r_in;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;

  multi_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_push  (w_push),
    .i_data  (req_data),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

`ifdef MULTI_DRIVER_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST =
    {{(TMO_W-1){1'b1}}, 1'b0};

  logic [TMO_W-1:0] r_tmo;
  logic             r_resp_err;

  assign resp_err = r_resp_err;
`else
  logic [TMO_W-1:0] w_unused_tmo;

  assign w_unused_tmo = '0;
  assign resp_err     = 1'b0;
`endif

  // issue/wait/respond sequencer, one operation in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_start      <= 1'b0;
      r_in         <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
`ifdef MULTI_DRIVER_TIMEOUT_EN
      r_tmo        <= '0;
      r_resp_err   <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_state <= S_ISSUE;
            r_start <= 1'b1;
            r_in    <= w_head;
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
          r_start <= 1'b0;
          r_in    <= '0;
`ifdef MULTI_DRIVER_TIMEOUT_EN
          r_tmo   <= '0;
`endif
        end
        S_WAIT: begin
          if (done) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_data  <= out;
`ifdef MULTI_DRIVER_TIMEOUT_EN
            r_resp_err   <= 1'b0;
          end else if (r_tmo == TMO_LAST) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b1;
          end else begin
            r_tmo <= r_tmo + 1'b1;
`endif
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_driver.sv
// tb_multi_driver: vector table plus scoreboard
// around a behavioural start/done unit.
module tb_multi_driver;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } sb_t;

  typedef struct {
    logic [31:0] d;
    int          lat;
    logic [31:0] key;
    logic [31:0] exp;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_data = '0;
  logic        start;
  logic [31:0] u_in;
  logic        done;
  logic [31:0] u_out;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic        resp_err;

  int total = 0;
  int bad = 0;

  logic        m_done = 1'b0;
  logic [31:0] m_out = '0;
  logic        inj_done = 1'b0;
  logic [31:0] inj_out = '0;
  logic        u_en = 1'b1;
  int          u_lat = 0;
  logic [31:0] u_key = '0;
  logic        pend = 1'b0;
  logic        prev_start = 1'b0;
  int          cnt = 0;
  logic [31:0] opnd = '0;
  int          nstart = 0;

  sb_t  sb[$];
  sb_t  cur_exp;
  logic acc = 1'b0;
  logic saw_full = 1'b0;

  assign done  = u_en ? m_done : inj_done;
  assign u_out = u_en ? m_out : inj_out;

  always #5 clock = ~clock;

  multi_driver #(
    .WIDTH (32),
    .DEPTH (4),
    .TMO_W (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .start      (start),
    .in         (u_in),
    .done       (done),
    .out        (u_out),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // sample at negedge, then step the unit model after posedge
  task automatic cyc();
    sb_t e;
    @(negedge clock);
    if (req_valid && req_ready) begin
      sb.push_back(cur_exp);
      acc = 1'b1;
    end
    if (!req_ready) saw_full = 1'b1;
    if (resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        chk("resp_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("resp_data", resp_data, e.d);
        chk("resp_err", {31'b0, resp_err}, {31'b0, e.e});
      end
    end
    @(posedge clock);
    #1;
    m_done = 1'b0;
    m_out  = '0;
    if (pend) begin
      if (cnt == 0) begin
        m_done = 1'b1;
        m_out  = opnd ^ u_key;
        pend   = 1'b0;
      end else begin
        cnt--;
      end
    end
    if (start) begin
      chk("one_in_flight", {30'b0, prev_start, pend}, 32'd0);
      pend = 1'b1;
      cnt  = u_lat;
      opnd = u_in;
      nstart++;
    end else begin
      chk("in_idle_zero", u_in, 32'd0);
    end
    prev_start = start;
  endtask

  task automatic send(input logic [31:0] d,
                      input logic [31:0] ed,
                      input logic ee,
                      input bit keep);
    int n;
    n = 0;
    acc = 1'b0;
    req_valid = 1'b1;
    req_data = d;
    cur_exp = '{d: ed, e: ee};
    while (!acc && n < 60) begin
      cyc();
      n++;
    end
    chk("send_accept", {31'b0, acc}, 32'd1);
    if (!keep) begin
      req_valid = 1'b0;
      req_data = '0;
    end
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max) begin
      cyc();
      n++;
    end
    chk("drain", sb.size(), 32'd0);
  endtask

  task automatic wait_rv(input int max);
    int n;
    n = 0;
    while (!resp_valid && n < max) begin
      cyc();
      n++;
    end
    chk("resp_valid_seen", {31'b0, resp_valid}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t vt[5];
    int   s0;
    int   n;
    logic stable;

    vt[0] = '{32'h0000_00A5, 1, 32'h0000_0000, 32'h0000_00A5};
    vt[1] = '{32'h1234_5678, 0, 32'hFFFF_0000, 32'hEDCB_5678};
    vt[2] = '{32'hFFFF_FFFF, 3, 32'hFFFF_FFFF, 32'h0000_0000};
    vt[3] = '{32'h0000_0000, 5, 32'h8000_0001, 32'h8000_0001};
    vt[4] = '{32'hDEAD_BEEF, 2, 32'h0F0F_0F0F, 32'hD1A2_B1E0};

    cyc();
    cyc();
    chk("rst_start", {31'b0, start}, 32'd0);
    chk("rst_in", u_in, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      u_lat = vt[i].lat;
      u_key = vt[i].key;
      s0 = nstart;
      send(vt[i].d, vt[i].exp, 1'b0, 1'b0);
      drain(60);
      chk("vec_starts", nstart - s0, 32'd1);
      chk("vec_operand", opnd, vt[i].d);
    end

    u_lat = 0;
    u_key = '0;
    saw_full = 1'b0;
    for (int k = 0; k < 5; k++)
      send(32'h100 + k, 32'h100 + k, 1'b0, k < 4);
    drain(100);
    chk("t2_full_seen", {31'b0, saw_full}, 32'd1);

    resp_ready = 1'b0;
    send(32'h300, 32'h300, 1'b0, 1'b0);
    wait_rv(40);
    s0 = nstart;
    stable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send(32'h310 + k, 32'h310 + k, 1'b0, k < 3);
      if (!resp_valid || resp_data !== 32'h300) stable = 1'b0;
    end
    for (int j = 0; j < 6; j++) begin
      cyc();
      if (!resp_valid || resp_data !== 32'h300) stable = 1'b0;
    end
    chk("t3_stable", {31'b0, stable}, 32'd1);
    chk("t3_hold_data", resp_data, 32'h300);
    chk("t3_no_start", nstart - s0, 32'd0);
    chk("t3_full", {31'b0, req_ready}, 32'd0);
    resp_ready = 1'b1;
    drain(100);

    s0 = nstart;
    u_en = 1'b0;
    inj_out = 32'hBAD0_BAD0;
    inj_done = 1'b1;
    cyc();
    cyc();
    inj_done = 1'b0;
    cyc();
    chk("t4_idle_valid", {31'b0, resp_valid}, 32'd0);
    chk("t4_idle_data", resp_data, 32'h313);
    chk("t4_idle_start", nstart - s0, 32'd0);
    u_en = 1'b1;
    resp_ready = 1'b0;
    send(32'h400, 32'h400, 1'b0, 1'b0);
    wait_rv(40);
    u_en = 1'b0;
    inj_done = 1'b1;
    cyc();
    cyc();
    inj_done = 1'b0;
    cyc();
    chk("t4_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("t4_resp_data", resp_data, 32'h400);
    u_en = 1'b1;
    resp_ready = 1'b1;
    drain(40);

    u_lat = 40;
    for (int k = 0; k < 4; k++)
      send(32'h500 + k, 32'h500 + k, 1'b0, k < 3);
    cyc();
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    sb.delete();
    pend = 1'b0;
    chk("t5_start", {31'b0, start}, 32'd0);
    chk("t5_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("t5_req_ready", {31'b0, req_ready}, 32'd1);
    s0 = nstart;
    for (int j = 0; j < 30; j++) cyc();
    chk("t5_no_issue", nstart - s0, 32'd0);
    chk("t5_no_resp", {31'b0, resp_valid}, 32'd0);
    u_lat = 0;

`ifdef MULTI_DRIVER_TIMEOUT_EN
    u_en = 1'b0;
    inj_done = 1'b0;
    resp_ready = 1'b0;
    s0 = nstart;
    send(32'h600, 32'h0, 1'b1, 1'b0);
    n = 0;
    while (nstart == s0 && n < 10) begin
      cyc();
      n++;
    end
    chk("t6_issued", nstart - s0, 32'd1);
    n = 0;
    while (!resp_valid && n < 40) begin
      cyc();
      n++;
    end
    chk("t6_latency", n, 32'd16);
    chk("t6_err", {31'b0, resp_err}, 32'd1);
    chk("t6_data", resp_data, 32'd0);
    inj_out = 32'h77;
    inj_done = 1'b1;
    cyc();
    inj_done = 1'b0;
    cyc();
    chk("t6_late_valid", {31'b0, resp_valid}, 32'd1);
    chk("t6_late_err", {31'b0, resp_err}, 32'd1);
    chk("t6_late_data", resp_data, 32'd0);
    resp_ready = 1'b1;
    drain(20);
    pend = 1'b0;
    u_en = 1'b1;
`else
    n = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
